// File: rtl/data_recv_if.sv
// Serial receive-side bundle: the line in, the received byte and its status pulses out.
interface data_recv_if;
    logic       rxd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  rxd,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

    modport master (
        output rxd,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/data_recv.sv
// 8N1 serial receiver: synchronizes rxd, samples each bit at its middle, and reports
// well-framed bytes on data_out with a data_valid pulse or bad stop bits with frame_err.
module data_recv #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input logic        clk,
    input logic        rst,
    data_recv_if.slave bus
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [2:0]      r_idx, w_idx_next;
    logic [7:0]      r_shift, w_shift_next;
    logic [7:0]      r_data_out, w_data_out_next;
    logic            r_data_valid, w_data_valid_next;
    logic            r_frame_err, w_frame_err_next;
    logic            r_sync1, r_sync2;
    logic            w_rxd_s;

    // Synchronizer resets to the idle line level so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxd_s = r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_shift      <= w_shift_next;
            r_data_out   <= w_data_out_next;
            r_data_valid <= w_data_valid_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_idx_next        = r_idx;
        w_shift_next      = r_shift;
        w_data_out_next   = r_data_out;
        w_data_valid_next = 1'b0;
        w_frame_err_next  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!w_rxd_s) begin
                    w_state_next = StStart;
                    w_cnt_next   = '0;
                end
            end
            StStart: begin
                if (r_cnt == CntHalf) begin
                    w_cnt_next = '0;
                    if (w_rxd_s) begin
                        w_state_next = StIdle;
                    end else begin
                        w_state_next = StData;
                        w_idx_next   = '0;
                    end
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StData: begin
                // Counting a full bit from mid-start lands every sample at mid-bit.
                if (r_cnt == CntLast) begin
                    w_cnt_next          = '0;
                    w_shift_next[r_idx] = w_rxd_s;
                    if (r_idx == 3'd7) begin
                        w_state_next = StStop;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StStop: begin
                // Leaving at mid-stop leaves half a bit of slack for a back-to-back start.
                if (r_cnt == CntLast) begin
                    w_cnt_next = '0;
                    if (w_rxd_s) begin
                        w_data_out_next   = r_shift;
                        w_data_valid_next = 1'b1;
                        w_state_next      = StIdle;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = StWaitHigh;
                    end
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StWaitHigh: begin
                if (w_rxd_s) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_data_recv.sv
// Directed bench for data_recv at 16 clocks per bit: frame table plus reset, glitch,
// break and back-to-back sequences.
module tb_data_recv;

    localparam int unsigned CLKS = 16;

    logic clk = 1'b0;
    logic rst;

    data_recv_if bus ();

    data_recv #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_out;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         last_lat = -1;
    int         gap_run = 0;
    int         max_gap = 0;
    bit         overlap = 1'b0;
    logic [7:0] out_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse/latency/busy-gap monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.data_valid) begin
            n_valid++;
            last_lat = cyc - start_cyc;
            out_log.push_back(bus.data_out);
        end
        if (bus.frame_err) n_ferr++;
        if (bus.data_valid && bus.frame_err) overlap = 1'b1;
        if (!bus.busy) begin
            gap_run++;
        end else begin
            if (gap_run > max_gap) max_gap = gap_run;
            gap_run = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // All drivers keep the invariant: current time is 1 ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int start_len);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            bus.rxd = fr[b];
            if (b == 0) start_cyc = cyc;
            idle(b == 0 ? start_len : CLKS);
        end
    endtask

    task automatic clear_counts();
        n_valid  = 0;
        n_ferr   = 0;
        last_lat = -1;
        out_log.delete();
    endtask

    initial begin
        logic [9:0] fr;
        bit         seen_busy;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_out: 8'hA5, exp_valid: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'h01, stop: 1'b1, exp_out: 8'h01, exp_valid: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'h80, stop: 1'b1, exp_out: 8'h80, exp_valid: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h5A, stop: 1'b0, exp_out: 8'h80, exp_valid: 0, exp_ferr: 1};
        vecs[4] = '{data: 8'h7E, stop: 1'b1, exp_out: 8'h7E, exp_valid: 1, exp_ferr: 0};
        vecs[5] = '{data: 8'hFF, stop: 1'b1, exp_out: 8'hFF, exp_valid: 1, exp_ferr: 0};

        rst     = 1'b0;
        bus.rxd = 1'b1;
        #1;
        idle(3);
        check("rst_data_out", {24'h0, bus.data_out}, 32'h00);
        check("rst_valid", {31'h0, bus.data_valid}, 32'h0);
        check("rst_ferr", {31'h0, bus.frame_err}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        rst = 1'b1;
        idle(5);

        for (int i = 0; i < 6; i++) begin
            clear_counts();
            send_frame(vecs[i].data, vecs[i].stop, CLKS);
            if (!vecs[i].stop) begin
                idle(100 - CLKS);
                check($sformatf("v%0d_busy_break", i), {31'h0, bus.busy}, 32'h1);
                bus.rxd = 1'b1;
                idle(4);
            end else begin
                idle(10);
            end
            check($sformatf("v%0d_n_valid", i), n_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_n_ferr", i), n_ferr, vecs[i].exp_ferr);
            check($sformatf("v%0d_data_out", i), {24'h0, bus.data_out}, {24'h0, vecs[i].exp_out});
            check($sformatf("v%0d_busy_end", i), {31'h0, bus.busy}, 32'h0);
            if (vecs[i].exp_valid != 0) check_rng($sformatf("v%0d_latency", i), last_lat, 152, 156);
        end

        // Reset in the middle of data bit 4 aborts the frame.
        clear_counts();
        fr = {1'b1, 8'hF0, 1'b0};
        for (int b = 0; b < 5; b++) begin
            bus.rxd = fr[b];
            idle(CLKS);
        end
        bus.rxd = fr[5];
        idle(CLKS / 2);
        rst = 1'b0;
        idle(3);
        check("abort_rst_data_out", {24'h0, bus.data_out}, 32'h00);
        check("abort_rst_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_rst_valid", {31'h0, bus.data_valid}, 32'h0);
        check("abort_rst_ferr", {31'h0, bus.frame_err}, 32'h0);
        bus.rxd = 1'b1;
        idle(2);
        rst = 1'b1;
        idle(20);
        check("abort_no_valid", n_valid, 0);
        check("abort_no_ferr", n_ferr, 0);
        send_frame(8'hC3, 1'b1, CLKS);
        idle(10);
        check("after_abort_valid", n_valid, 1);
        check("after_abort_data", {24'h0, bus.data_out}, 32'hC3);

        // Start bit already low when reset releases.
        clear_counts();
        rst     = 1'b0;
        bus.rxd = 1'b0;
        idle(2);
        rst = 1'b1;
        send_frame(8'h96, 1'b1, CLKS - 2);
        idle(10);
        check("rxd_low_release_valid", n_valid, 1);
        check("rxd_low_release_data", {24'h0, bus.data_out}, 32'h96);
        check("rxd_low_release_ferr", n_ferr, 0);

        // Five-cycle glitch on the idle line.
        clear_counts();
        bus.rxd = 1'b0;
        idle(5);
        bus.rxd = 1'b1;
        idle(30);
        check("glitch_no_valid", n_valid, 0);
        check("glitch_no_ferr", n_ferr, 0);
        check("glitch_data_out", {24'h0, bus.data_out}, 32'h96);
        check("glitch_busy", {31'h0, bus.busy}, 32'h0);

        // Three frames with no idle between stop and next start.
        clear_counts();
        seen_busy = 1'b0;
        fork
            begin
                send_frame(8'h00, 1'b1, CLKS);
                send_frame(8'hFF, 1'b1, CLKS);
                send_frame(8'h3C, 1'b1, CLKS);
            end
            begin
                for (int k = 0; k < 50 && !seen_busy; k++) begin
                    @(posedge clk);
                    #1;
                    if (bus.busy) seen_busy = 1'b1;
                end
                gap_run = 0;
                max_gap = 0;
            end
        join
        idle(10);
        check("b2b_busy_seen", {31'h0, seen_busy}, 32'h1);
        check("b2b_n_valid", n_valid, 3);
        check("b2b_out0", {24'h0, (out_log.size() > 0) ? out_log[0] : 8'hxx}, 32'h00);
        check("b2b_out1", {24'h0, (out_log.size() > 1) ? out_log[1] : 8'hxx}, 32'hFF);
        check("b2b_out2", {24'h0, (out_log.size() > 2) ? out_log[2] : 8'hxx}, 32'h3C);
        check("b2b_n_ferr", n_ferr, 0);
        check_rng("b2b_busy_gap", max_gap, 1, 9);

        check("valid_ferr_overlap", {31'h0, overlap}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_recv.md
DATA_RECV -- requirements
Module: data_recv

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal values are even integers 4..1024.
REQ-002 Port clk  input  1  is the single system clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: asynchronous and active-low.
REQ-004 Port rxd  input  1  SHALL be the asynchronous serial line, idle high, driven by the upstream data_send txd.
REQ-005 Port data_out  output  8  SHALL carry the last correctly framed received byte.
REQ-006 Port data_valid  output  1  SHALL be a one-cycle pulse marking a new byte on data_out.
REQ-007 Port frame_err  output  1  SHALL be a one-cycle pulse marking a byte rejected for a bad stop bit.
REQ-008 Port busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-009 Line format SHALL be: start bit 0, 8 data bits LSB first, stop bit 1, each CLKS_PER_BIT cycles long.
REQ-010 rxd SHALL pass through a 2-flop synchronizer, giving rxd_s; all decisions SHALL use rxd_s only.
REQ-011 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH, plus a bit-cycle counter cnt and a bit index idx (0..7).
REQ-012 In IDLE, when rxd_s=0, the FSM SHALL go to START with cnt=0.
REQ-013 In START, at cnt=CLKS_PER_BIT/2-1 (mid-bit), rxd_s=0 SHALL go to DATA with cnt=0 and idx=0; rxd_s=1 SHALL return to IDLE (glitch rejection, no pulse).
REQ-014 In DATA, at cnt=CLKS_PER_BIT-1, rxd_s SHALL be shifted into bit idx of a shift register, and cnt SHALL reset; after idx=7 the FSM SHALL go to STOP, otherwise idx SHALL increment.
REQ-015 In STOP, at cnt=CLKS_PER_BIT-1 with rxd_s=1, the FSM SHALL load data_out from the shift register, pulse data_valid high for exactly one cycle, and go to IDLE.
REQ-016 In STOP, at cnt=CLKS_PER_BIT-1 with rxd_s=0, the FSM SHALL pulse frame_err for one cycle, leave data_out unchanged, and go to WAIT_HIGH.
REQ-017 In WAIT_HIGH, the FSM SHALL stay until rxd_s=1, then go to IDLE; a low line (break) SHALL never produce further pulses.
REQ-018 data_valid and frame_err SHALL never be high in the same cycle.
REQ-019 data_out SHALL hold its value between data_valid pulses.
REQ-020 Back-to-back frames with zero idle between stop and next start SHALL all be received, because STOP returns to IDLE at mid-stop-bit.
REQ-021 The counter SHALL be wide enough for CLKS_PER_BIT-1 with no wrap-around inside a bit.
REQ-022 data_valid SHALL rise 152..156 cycles after the rxd falling start edge when CLKS_PER_BIT=16; in general, latency is 2+CLKS_PER_BIT/2+9*CLKS_PER_BIT ±2 cycles.

Reset
REQ-023 While rst=0, the block SHALL hold state=IDLE, cnt=0, idx=0, shift register=0, data_out=8'h00, data_valid=0, frame_err=0, busy=0, and synchronizer flops=1.
REQ-024 An rst assertion mid-frame SHALL abort the frame immediately, with no pulse.
REQ-025 After rst is released with rxd low, the block SHALL enter START only after the synchronizer shows 0, and SHALL treat it as a normal start.

Verification (CLKS_PER_BIT=16)
REQ-026 Send frame 0xA5 -> one data_valid pulse within 152..156 cycles of the start edge, data_out=0xA5, frame_err never high.
REQ-027 Send 0x00, 0xFF and 0x3C back-to-back with no idle gap -> three data_valid pulses, data_out values in that order, busy low for at most 9 cycles between frames.
REQ-028 Drive a 5-cycle low glitch on idle rxd -> FSM returns to IDLE, no data_valid, no frame_err, data_out unchanged.
REQ-029 Send 0x5A with the stop bit forced to 0 and rxd held low for 100 cycles -> one frame_err pulse, no data_valid, busy high until rxd returns high, data_out keeps its previous value.
REQ-030 Assert rst at data bit 4 of a frame, release it, then send 0xC3 -> outputs at reset values during rst, no pulse for the aborted frame, data_out=0xC3 for the next frame.
